// File: rtl/operand_fetch_seq.sv
// Addressing-mode sequencer: walks the 6502 operand/pointer fetch cycles, drives the
// address mux select and builds the effective address in dirh:dirl (pointer in indirh:indirl).
module operand_fetch_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] mode,
  input  logic [7:0] index_x,
  input  logic [7:0] index_y,
  input  logic [7:0] data_in,
  output logic [2:0] address_select,
  output logic       pc_inc,
  output logic [7:0] dirl,
  output logic [7:0] dirh,
  output logic [7:0] indirl,
  output logic [7:0] indirh,
  output logic       busy,
  output logic       done,
  output logic       page_cross
);

  typedef enum logic [2:0] {
    S_IDLE, S_OP_LO, S_OP_HI, S_PTR_LO, S_PTR_HI, S_DONE
  } state_t;

  localparam logic [3:0] M_ZPG = 4'd0;
  localparam logic [3:0] M_ZPX = 4'd1;
  localparam logic [3:0] M_ZPY = 4'd2;
  localparam logic [3:0] M_ABS = 4'd3;
  localparam logic [3:0] M_ABX = 4'd4;
  localparam logic [3:0] M_ABY = 4'd5;
  localparam logic [3:0] M_IND = 4'd6;
  localparam logic [3:0] M_IZX = 4'd7;
  localparam logic [3:0] M_IZY = 4'd8;

  localparam logic [2:0] SEL_PC       = 3'b000;
  localparam logic [2:0] SEL_ZP_PTR   = 3'b011;
  localparam logic [2:0] SEL_ZP_PTR1  = 3'b100;
  localparam logic [2:0] SEL_PTR      = 3'b101;
  localparam logic [2:0] SEL_PTR_INC  = 3'b110;

  state_t     state;
  logic [3:0] mode_q;
  logic [7:0] x_q;
  logic [7:0] y_q;
  logic [7:0] index_val;
  logic [8:0] index_sum;

  // Only ABX indexes with X at the high-byte stage; ABY and IZY both use Y.
  assign index_val = (mode_q == M_ABX) ? x_q : y_q;
  assign index_sum = {1'b0, dirl} + {1'b0, index_val};

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // NOTE: every output of this always_comb gets a default first so no latch is inferred.
  always_comb begin
    address_select = SEL_PC;
    pc_inc         = 1'b0;
    unique case (state)
      S_OP_LO, S_OP_HI: pc_inc = 1'b1;
      S_PTR_LO:         address_select = (mode_q == M_IND) ? SEL_PTR : SEL_ZP_PTR;
      S_PTR_HI:         address_select = (mode_q == M_IND) ? SEL_PTR_INC : SEL_ZP_PTR1;
      default:          ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every capture sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mode_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      dirl       <= '0;
      dirh       <= '0;
      indirl     <= '0;
      indirh     <= '0;
      page_cross <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            x_q        <= index_x;
            y_q        <= index_y;
            page_cross <= 1'b0;
            state      <= (mode > M_IZY) ? S_DONE : S_OP_LO;
          end
        end

        S_OP_LO: begin
          unique case (mode_q)
            M_ZPG: begin dirl <= data_in;         dirh <= 8'h00; state <= S_DONE; end
            M_ZPX: begin dirl <= data_in + x_q;   dirh <= 8'h00; state <= S_DONE; end
            M_ZPY: begin dirl <= data_in + y_q;   dirh <= 8'h00; state <= S_DONE; end
            M_ABS, M_ABX, M_ABY: begin dirl <= data_in;        state <= S_OP_HI;  end
            M_IND: begin indirl <= data_in;                    state <= S_OP_HI;  end
            M_IZX: begin indirl <= data_in + x_q;              state <= S_PTR_LO; end
            M_IZY: begin indirl <= data_in;                    state <= S_PTR_LO; end
            default: state <= S_DONE;
          endcase
        end

        S_OP_HI: begin
          state <= S_DONE;
          unique case (mode_q)
            M_ABS: dirh <= data_in;
            M_ABX, M_ABY: begin
              dirl       <= index_sum[7:0];
              dirh       <= data_in + {7'b0, index_sum[8]};
              page_cross <= index_sum[8];
            end
            M_IND: begin
              indirh <= data_in;
              state  <= S_PTR_LO;
            end
            default: ;
          endcase
        end

        S_PTR_LO: begin
          dirl  <= data_in;
          state <= S_PTR_HI;
        end

        S_PTR_HI: begin
          if (mode_q == M_IZY) begin
            dirl       <= index_sum[7:0];
            dirh       <= data_in + {7'b0, index_sum[8]};
            page_cross <= index_sum[8];
          end else begin
            dirh <= data_in;
          end
          state <= S_DONE;
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Self-checking bench for operand_fetch_seq: a memory model answers the address mux,
// an arithmetic reference model predicts each sequence, and a monitor scores on done.
module tb_operand_fetch_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] mode;
  logic [7:0] index_x;
  logic [7:0] index_y;
  logic [7:0] data_in;
  logic [2:0] address_select;
  logic       pc_inc;
  logic [7:0] dirl, dirh, indirl, indirh;
  logic       busy, done, page_cross;

  operand_fetch_seq dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .index_x(index_x), .index_y(index_y), .data_in(data_in),
    .address_select(address_select), .pc_inc(pc_inc),
    .dirl(dirl), .dirh(dirh), .indirl(indirl), .indirh(indirh),
    .busy(busy), .done(done), .page_cross(page_cross)
  );

  always #5 clk = ~clk;

  // Memory and program counter seen by the sequencer through the address mux.
  logic [7:0]  mem [0:65535];
  logic [15:0] pc;
  logic [15:0] addr;

  always @(posedge clk or posedge reset) begin
    if (reset)       pc <= 16'h0400;
    else if (pc_inc) pc <= pc + 16'd1;
  end

  always_comb begin
    addr = pc;
    case (address_select)
      3'b011:  addr = {8'h00, indirl};
      3'b100:  addr = {8'h00, 8'(indirl + 8'd1)};
      3'b101:  addr = {indirh, indirl};
      3'b110:  addr = {indirh, indirl} + 16'd1;
      default: addr = pc;
    endcase
    data_in = mem[addr];
  end

  typedef struct {
    logic [7:0]  dirl, dirh, indirl, indirh;
    logic        page_cross;
    int          latency;
    int          pc_incs;
    logic [14:0] sel_trace;
  } exp_t;

  exp_t q[$];
  exp_t model;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: effective address from plain 16-bit arithmetic over the memory image.
  function automatic exp_t predict(input logic [3:0] md, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int op8, op16, zp, base, idx, ea;
    e = model;
    e.page_cross = 1'b0;
    op8  = int'(mem[pc]);
    op16 = op8 | (int'(mem[16'(pc + 16'd1)]) << 8);
    case (md)
      4'd0, 4'd1, 4'd2: begin
        ea = (md == 4'd1) ? (op8 + int'(x)) % 256 : (md == 4'd2) ? (op8 + int'(y)) % 256 : op8;
        e.dirl = 8'(ea); e.dirh = 8'h00;
        e.latency = 2; e.pc_incs = 1; e.sel_trace = 15'o00000;
      end
      4'd3, 4'd4, 4'd5: begin
        idx = (md == 4'd4) ? int'(x) : (md == 4'd5) ? int'(y) : 0;
        ea  = (op16 + idx) % 65536;
        e.page_cross = ((op16 % 256) + idx) > 255;
        e.dirl = 8'(ea); e.dirh = 8'(ea >> 8);
        e.latency = 3; e.pc_incs = 2; e.sel_trace = 15'o00000;
      end
      4'd6: begin
        e.indirl = 8'(op16); e.indirh = 8'(op16 >> 8);
        ea = int'(mem[16'(op16)]) | (int'(mem[16'((op16 + 1) % 65536)]) << 8);
        e.dirl = 8'(ea); e.dirh = 8'(ea >> 8);
        e.latency = 5; e.pc_incs = 2; e.sel_trace = 15'o00560;
      end
      4'd7, 4'd8: begin
        zp   = (md == 4'd7) ? (op8 + int'(x)) % 256 : op8;
        e.indirl = 8'(zp);
        base = int'(mem[16'(zp)]) | (int'(mem[16'((zp + 1) % 256)]) << 8);
        idx  = (md == 4'd8) ? int'(y) : 0;
        ea   = (base + idx) % 65536;
        if (md == 4'd8) e.page_cross = ((base % 256) + idx) > 255;
        e.dirl = 8'(ea); e.dirh = 8'(ea >> 8);
        e.latency = 4; e.pc_incs = 1; e.sel_trace = 15'o00340;
      end
      default: begin
        e.latency = 1; e.pc_incs = 0; e.sel_trace = 15'o00000;
      end
    endcase
    return e;
  endfunction

  // Monitor: accumulates the busy-cycle trace and scores it when done is presented.
  initial begin : monitor
    logic [14:0] trace;
    int          cyc, incs;
    exp_t        e;
    trace = '0; cyc = 0; incs = 0;
    forever begin
      @(negedge clk);
      if (busy && !reset) begin
        trace = {trace[11:0], address_select};
        cyc++;
        incs += int'(pc_inc);
        if (done) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
          end else begin
            e = q.pop_front();
            check("dirl",       32'(dirl),       32'(e.dirl));
            check("dirh",       32'(dirh),       32'(e.dirh));
            check("indirl",     32'(indirl),     32'(e.indirl));
            check("indirh",     32'(indirh),     32'(e.indirh));
            check("page_cross", 32'(page_cross), 32'(e.page_cross));
            check("latency",    32'(cyc),        32'(e.latency));
            check("pc_inc_cnt", 32'(incs),       32'(e.pc_incs));
            check("sel_trace",  32'(trace),      32'(e.sel_trace));
          end
          trace = '0; cyc = 0; incs = 0;
        end
      end else begin
        trace = '0; cyc = 0; incs = 0;
      end
    end
  end

  // Issue one sequence; optionally pulse start again while busy with a different mode.
  task automatic run_seq(input logic [3:0] md, input logic [7:0] x, input logic [7:0] y,
                         input bit glitch);
    exp_t e;
    bit   timed_out;
    @(negedge clk);
    mode = md; index_x = x; index_y = y; start = 1'b1;
    e = predict(md, x, y);
    q.push_back(e);
    model = e;
    @(negedge clk);
    start = 1'b0;
    mode = 4'($urandom); index_x = 8'($urandom); index_y = 8'($urandom);
    timed_out = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      if (glitch && i == 1) begin
        start = 1'b1; mode = 4'($urandom_range(0, 8));
      end
      @(negedge clk);
      start = 1'b0;
    end
    if (timed_out) begin
      checks++; errors++;
      $display("FAIL seq_timeout actual=busy required=idle mode=%0d", md);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = '0; index_x = '0; index_y = '0;
    model = '{default: '0};
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_sel",  32'(address_select), 0);
    check("rst_dir",  32'({dirh, dirl, indirh, indirl}), 0);
    reset = 1'b0;

    // Abort an ABS sequence in OP_HI; outputs must clear before the next edge.
    mem[pc] = 8'h77; mem[pc + 16'd1] = 8'h66;
    @(negedge clk);
    mode = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("op_hi_pc_inc", 32'(pc_inc), 1);
    check("op_hi_dirl", 32'(dirl), 32'h77);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_pc_inc", 32'(pc_inc), 0);
    check("abort_dir",  32'({dirh, dirl}), 0);
    @(negedge clk);
    reset = 1'b0;
    model = '{default: '0};
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(done), 0);
    end

    // Directed cases from the addressing-mode corner list.
    mem[pc] = 8'h44;
    run_seq(4'd0, 8'h00, 8'h00, 1'b0);
    mem[pc] = 8'h20;
    run_seq(4'd1, 8'hF0, 8'h00, 1'b0);
    mem[pc] = 8'hFF; mem[pc + 16'd1] = 8'h12;
    run_seq(4'd4, 8'h01, 8'h00, 1'b0);
    mem[pc] = 8'h34; mem[pc + 16'd1] = 8'h12; mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
    run_seq(4'd6, 8'h00, 8'h00, 1'b0);
    mem[pc] = 8'hFF; mem[16'h00FF] = 8'hF8; mem[16'h0000] = 8'h20;
    run_seq(4'd8, 8'h00, 8'h10, 1'b0);
    mem[pc] = 8'h10; mem[16'h0015] = 8'h00; mem[16'h0016] = 8'h80;
    run_seq(4'd7, 8'h05, 8'h00, 1'b1);
    run_seq(4'd12, 8'h00, 8'h00, 1'b0);

    // Randomised sequences, including start pulses while busy.
    for (int n = 0; n < 80; n++)
      run_seq(($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)),
              8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch_seq.md
Name: operand_fetch_seq

Overview:
- Addressing-mode sequencer that generates the pointer/operand bytes consumed by the CPU address multiplexer.
- On a start request, it:
  - walks through the 6502 addressing-mode fetch cycles;
  - drives address_select each cycle;
  - captures data_in into dirl/dirh/indirl/indirh;
  - applies X/Y indexing.
- Sits between the control unit (start/mode) and the address mux/memory data bus.

Parameters:
- None. Widths are fixed by the 6502 datapath: 8-bit data, 16-bit address.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request a fetch sequence; sampled only in IDLE
- mode  in  4  addressing mode, latched at start: 0 ZPG, 1 ZPX, 2 ZPY, 3 ABS, 4 ABX, 5 ABY, 6 IND, 7 IZX, 8 IZY, 9-15 invalid
- index_x  in  8  X register, latched at start
- index_y  in  8  Y register, latched at start
- data_in  in  8  memory read data; valid in the same cycle as the address it answers (combinational read)
- address_select  out  3  mux select: 000 PC, 011 {00,indirl}, 100 {00,indirl+1}, 101 {indirh,indirl}, 110 {indirh,indirl}+1
- pc_inc  out  1  PC increments at this clock edge
- dirl  out  8  effective address low byte (registered)
- dirh  out  8  effective address high byte (registered)
- indirl  out  8  pointer low byte (registered)
- indirh  out  8  pointer high byte (registered)
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse; outputs final
- page_cross  out  1  carry out of low-byte index add (ABX/ABY/IZY only); else 0; held until next start

Behaviour:
- Reset (async): state IDLE, all registered outputs 0, address_select 000, pc_inc 0.
- States: IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, DONE.
- Each state presents address_select combinationally from state; data_in is captured at the closing edge of that state.
- IDLE:
  - address_select 000, pc_inc 0.
  - start=1: latch mode/X/Y, clear page_cross, go to OP_LO.
  - Invalid mode: go to DONE with dir/indir registers unchanged.
- OP_LO: select 000, pc_inc=1. Capture per mode:
  - ZPG: dirl=d, dirh=00.
  - ZPX: dirl=(d+X) mod 256, dirh=00.
  - ZPY: dirl=(d+Y) mod 256, dirh=00.
  - ABS/ABX/ABY: dirl=d.
  - IND: indirl=d.
  - IZX: indirl=(d+X) mod 256.
  - IZY: indirl=d.
- OP_LO next state: ZP* go to DONE; ABS/ABX/ABY/IND go to OP_HI; IZX/IZY go to PTR_LO.
- OP_HI: select 000, pc_inc=1. Capture per mode:
  - ABS: dirh=d.
  - ABX: {dirh,dirl}={d,dirl}+X, 16-bit with wrap at FFFF; page_cross=carry out of bit 7.
  - ABY: as ABX with Y.
  - IND: indirh=d, next PTR_LO.
  - All others in this group go to DONE.
- PTR_LO: select 101 for IND, 011 for IZX/IZY; pc_inc=0. Capture dirl=d. Next PTR_HI.
- PTR_HI: select 110 for IND, 100 for IZX/IZY; pc_inc=0.
  - IND and IZX: dirh=d.
  - IZY: {dirh,dirl}={d,dirl}+Y; page_cross=carry out of bit 7.
  - Next DONE.
- DONE: select 000, pc_inc 0, done=1, busy=1. Next IDLE unconditionally; start is ignored in DONE.
- Latency (start edge to done): ZP* 2 cycles; ABS/ABX/ABY 3; IZX/IZY 4; IND 5.
- start while busy: ignored; in-flight sequence is unaffected.
- Pointer wrap:
  - IZX/IZY pointer stays in zero page (indirl+1 wraps 8-bit via select 100).
  - IND uses full 16-bit pointer+1 via select 110.
- reset mid-sequence: immediate return to IDLE with all outputs 0; no done pulse.
- Registers not written by a mode keep their previous values.

Test Plan:
- Reset during OP_HI of ABS -> state IDLE, dirl/dirh/busy/done=0 immediately (before next edge); following start with mode 0, data 0x44 -> dirl=44, dirh=00, done 2 cycles after start, pc_inc high exactly 1 cycle.
- ZPX, X=0xF0, data 0x20 -> dirl=0x10 (wrap), dirh=00, page_cross=0.
- ABX, X=0x01, data 0xFF then 0x12 -> {dirh,dirl}=0x1300, page_cross=1, pc_inc high 2 cycles, done at cycle 3.
- IND, data 0x34, 0x12, 0xCD, 0xAB -> indir=0x1234, select sequence 000,000,101,110,000, dir=0xABCD, done at cycle 5.
- IZY, Y=0x10, zp byte 0xFF, mem[00FF]=0xF8, mem[0000]=0x20 -> select 011 then 100 (address 0x0000), dir=0x2108, page_cross=1.
- IZX, X=0x05, zp byte 0x10, mem[0015]=0x00, mem[0016]=0x80 -> indirl=0x15, dir=0x8000. Start pulsed mid-sequence is ignored. Invalid mode 12 -> done after 1 cycle, dir/indir registers unchanged.
